friscv_cache_line_loader: RTL and testbench



---
 rtl/friscv_cache_line_loader.sv | 151 +++++++++++++++
 tb/tb_friscv_cache_line_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_cache_line_loader.sv
// Instruction-cache line loader: turns a single-beat line-fill request into an AXI4 read
// and writes the returned block into the cache. Optional macro CACHE_RID_CHECK_EN drops R beats with a foreign ID.
module friscv_cache_line_loader #(
  parameter string NAME       = "line_loader",
  parameter int    AXI_ADDR_W = 32,
  parameter int    AXI_ID_W   = 8,
  parameter int    AXI_DATA_W = 128
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  memctrl_arvalid,
  output logic                  memctrl_arready,
  input  logic [AXI_ADDR_W-1:0] memctrl_araddr,
  input  logic [2:0]            memctrl_arprot,
  input  logic [AXI_ID_W-1:0]   memctrl_arid,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  output logic [AXI_ADDR_W-1:0] mem_araddr,
  output logic [7:0]            mem_arlen,
  output logic [2:0]            mem_arsize,
  output logic [1:0]            mem_arburst,
  output logic [2:0]            mem_arprot,
  output logic [AXI_ID_W-1:0]   mem_arid,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic [AXI_ID_W-1:0]   mem_rid,
  input  logic [1:0]            mem_rresp,
  input  logic [AXI_DATA_W-1:0] mem_rdata,
  input  logic                  mem_rlast,
  output logic                  cache_writing,
  output logic                  cache_wen,
  output logic [AXI_ADDR_W-1:0] cache_waddr,
  output logic [AXI_DATA_W-1:0] cache_wdata,
  output logic                  rd_error,
  output logic [2:0]            debug_state
);

  localparam int ADDR_LSB_W = $clog2(AXI_DATA_W / 8);
  localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = {AXI_ADDR_W{1'b1}} << ADDR_LSB_W;
  // The tracer file suffix has no hardware meaning.
  localparam string tracer_unused_name = NAME;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    RESP   = 3'd2,
    WRITE  = 3'd3,
    SETTLE = 3'd4
  } state_t;

  state_t r_state;
  logic   w_rid_ok;

  // Single beat of a block-sized transfer: fixed burst shape.
  assign mem_arlen   = 8'd0;
  assign mem_arsize  = 3'(ADDR_LSB_W);
  assign mem_arburst = 2'b01;
  assign debug_state = r_state;

`ifdef CACHE_RID_CHECK_EN
  assign w_rid_ok = (mem_rid == mem_arid);
  wire w_unused = &{1'b0, mem_rlast};
`else
  assign w_rid_ok = 1'b1;
  wire w_unused = &{1'b0, mem_rlast, mem_rid};
`endif

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // a valid, once raised, holds its payload stable until that edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state         <= IDLE;
      memctrl_arready <= 1'b0;
      mem_arvalid     <= 1'b0;
      mem_araddr      <= '0;
      mem_arprot      <= '0;
      mem_arid        <= '0;
      mem_rready      <= 1'b0;
      cache_writing   <= 1'b0;
      cache_wen       <= 1'b0;
      cache_waddr     <= '0;
      cache_wdata     <= '0;
      rd_error        <= 1'b0;
    end else if (srst) begin
      r_state         <= IDLE;
      memctrl_arready <= 1'b0;
      mem_arvalid     <= 1'b0;
      mem_araddr      <= '0;
      mem_arprot      <= '0;
      mem_arid        <= '0;
      mem_rready      <= 1'b0;
      cache_writing   <= 1'b0;
      cache_wen       <= 1'b0;
      cache_waddr     <= '0;
      cache_wdata     <= '0;
      rd_error        <= 1'b0;
    end else begin
      rd_error <= 1'b0;
      case (r_state)
        IDLE: begin
          memctrl_arready <= 1'b1;
          if (memctrl_arvalid && memctrl_arready) begin
            memctrl_arready <= 1'b0;
            mem_arvalid     <= 1'b1;
            mem_araddr      <= memctrl_araddr & ADDR_MASK;
            mem_arprot      <= memctrl_arprot;
            mem_arid        <= memctrl_arid;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            if (!w_rid_ok) begin
              rd_error <= 1'b1;
            end else begin
              // An error response still fills the line so the prefetcher never stalls.
              cache_wdata   <= mem_rdata;
              cache_waddr   <= mem_araddr;
              mem_rready    <= 1'b0;
              cache_wen     <= 1'b1;
              cache_writing <= 1'b1;
              rd_error      <= (mem_rresp != 2'b00);
              r_state       <= WRITE;
            end
          end
        end
        WRITE: begin
          cache_wen <= 1'b0;
          r_state   <= SETTLE;
        end
        SETTLE: begin
          cache_writing   <= 1'b0;
          memctrl_arready <= 1'b1;
          r_state         <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_cache_line_loader.sv
// Bench for friscv_cache_line_loader: event-time reference model, random memory responder,
// per-cycle compare process and a line-write scoreboard.
module tb_friscv_cache_line_loader;

  localparam int AW = 32;
  localparam int IW = 8;
  localparam int DW = 128;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          srst = 1'b0;
  logic          memctrl_arvalid = 1'b0;
  logic          memctrl_arready;
  logic [AW-1:0] memctrl_araddr = '0;
  logic [2:0]    memctrl_arprot = '0;
  logic [IW-1:0] memctrl_arid = '0;
  logic          mem_arvalid;
  logic          mem_arready = 1'b0;
  logic [AW-1:0] mem_araddr;
  logic [7:0]    mem_arlen;
  logic [2:0]    mem_arsize;
  logic [1:0]    mem_arburst;
  logic [2:0]    mem_arprot;
  logic [IW-1:0] mem_arid;
  logic          mem_rvalid = 1'b0;
  logic          mem_rready;
  logic [IW-1:0] mem_rid = '0;
  logic [1:0]    mem_rresp = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rlast = 1'b0;
  logic          cache_writing;
  logic          cache_wen;
  logic [AW-1:0] cache_waddr;
  logic [DW-1:0] cache_wdata;
  logic          rd_error;
  logic [2:0]    debug_state;

  friscv_cache_line_loader dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .memctrl_arvalid(memctrl_arvalid), .memctrl_arready(memctrl_arready),
    .memctrl_araddr(memctrl_araddr), .memctrl_arprot(memctrl_arprot), .memctrl_arid(memctrl_arid),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_arprot(mem_arprot), .mem_arid(mem_arid),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rid(mem_rid),
    .mem_rresp(mem_rresp), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .cache_writing(cache_writing), .cache_wen(cache_wen), .cache_waddr(cache_waddr),
    .cache_wdata(cache_wdata), .rd_error(rd_error), .debug_state(debug_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outputs follow from the cycle indices of the last request, AR and R handshakes.
  int cyc = 0;
  int idle_from = 32'h3fff_ffff;
  int t_req = -1, t_ar = -1, t_r = -1, t_err = -10;
  int last_req = -100, last_r = -100, last_err = -100;
  int gap_from_r = 0, req_gap = 0;
  logic [AW-1:0] m_addr = '0;
  logic [IW-1:0] m_id = '0;
  logic [2:0]    m_prot = '0;
  bit e_arready = 0, e_arvalid = 0, e_rready = 0, e_wen = 0, e_writing = 0, e_err = 0;
  logic [AW+DW-1:0] exp_q[$];

  always @(posedge aclk) begin
    bit rst_edge;
    bit id_ok;
    rst_edge = !aresetn || srst;
    if (!rst_edge) begin
      if (memctrl_arvalid && e_arready) begin
        gap_from_r = cyc - last_r;
        req_gap    = cyc - last_req;
        t_req = cyc; last_req = cyc; t_ar = -1; t_r = -1;
        m_addr = (memctrl_araddr / 16) * 16;
        m_id   = memctrl_arid;
        m_prot = memctrl_arprot;
      end
      if (e_arvalid && mem_arready) t_ar = cyc;
      if (e_rready && mem_rvalid) begin
        id_ok = 1'b1;
`ifdef CACHE_RID_CHECK_EN
        id_ok = (mem_rid == m_id);
`endif
        if (!id_ok) begin
          t_err = cyc; last_err = cyc;
        end else begin
          t_r = cyc; last_r = cyc;
          exp_q.push_back({m_addr, mem_rdata});
          if (mem_rresp != 2'b00) begin
            t_err = cyc; last_err = cyc;
          end
        end
      end
    end
    cyc++;
    if (rst_edge) begin
      idle_from = cyc + 1;
      t_req = -1; t_ar = -1; t_r = -1; t_err = -10;
      exp_q.delete();
    end
    e_arready = (cyc >= idle_from) && (t_req < 0 || (t_r >= 0 && cyc >= t_r + 3));
    e_arvalid = (t_req >= 0) && (t_ar < 0);
    e_rready  = (t_ar >= 0) && (t_r < 0);
    e_wen     = (t_r >= 0) && (cyc == t_r + 1);
    e_writing = (t_r >= 0) && (cyc == t_r + 1 || cyc == t_r + 2);
    e_err     = (cyc == t_err + 1);
  end

  // ---------------- compare process ----------------
  always @(negedge aclk) begin
    logic [AW+DW-1:0] ent;
    if (!aresetn || cyc < idle_from) begin
      check("rst_memctrl_arready", memctrl_arready, 0);
      check("rst_mem_arvalid", mem_arvalid, 0);
      check("rst_mem_rready", mem_rready, 0);
      check("rst_cache_wen", cache_wen, 0);
      check("rst_cache_writing", cache_writing, 0);
      check("rst_rd_error", rd_error, 0);
      check("rst_mem_araddr", mem_araddr, 0);
      check("rst_mem_arid", mem_arid, 0);
      check("rst_cache_waddr", cache_waddr, 0);
      check("rst_cache_wdata", cache_wdata, 0);
    end else begin
      check("memctrl_arready", memctrl_arready, e_arready);
      check("mem_arvalid", mem_arvalid, e_arvalid);
      check("mem_rready", mem_rready, e_rready);
      check("cache_wen", cache_wen, e_wen);
      check("cache_writing", cache_writing, e_writing);
      check("rd_error", rd_error, e_err);
      if (e_arvalid) begin
        check("mem_araddr", mem_araddr, m_addr);
        check("mem_arid", mem_arid, m_id);
        check("mem_arprot", mem_arprot, m_prot);
        check("mem_arlen", mem_arlen, 0);
        check("mem_arsize", mem_arsize, 4);
        check("mem_arburst", mem_arburst, 1);
      end
      if (e_wen) begin
        check("line_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          check("cache_waddr", cache_waddr, ent[AW+DW-1:DW]);
          check("cache_wdata", cache_wdata, ent[DW-1:0]);
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  int cfg_ar_lat = 0, cfg_r_lat = 0, cfg_bad = 0;
  bit cfg_fixed = 0, cfg_rand = 0, cfg_noise = 0;
  logic [DW-1:0] cfg_data = '0;
  logic [1:0]    cfg_resp = '0;

  initial begin : responder
    bit p_arvalid, p_rready, rst_edge, ar_hs, r_hs, busy;
    int ar_cnt, r_cnt, bad_left;
    logic [IW-1:0] rid_cur;
    busy = 0; ar_cnt = 0; r_cnt = 0; bad_left = 0; rid_cur = '0;
    forever begin
      @(negedge aclk);
      p_arvalid = mem_arvalid;
      p_rready  = mem_rready;
      @(posedge aclk);
      rst_edge = !aresetn || srst;
      ar_hs = p_arvalid && mem_arready;
      r_hs  = p_rready && mem_rvalid;
      #1;
      if (rst_edge) begin
        mem_arready = 0; mem_rvalid = 0; mem_rlast = 0; busy = 0; ar_cnt = 0;
      end else begin
        if (!busy && mem_rvalid) begin
          mem_rvalid = 0; mem_rlast = 0;
        end
        if (ar_hs) begin
          mem_arready = 0; ar_cnt = 0; busy = 1;
          r_cnt = cfg_r_lat; bad_left = cfg_bad; rid_cur = mem_arid;
        end else if (mem_arvalid && !mem_arready) begin
          if (ar_cnt >= cfg_ar_lat) mem_arready = 1;
          else ar_cnt++;
        end
        if (r_hs && busy) begin
          mem_rvalid = 0; mem_rlast = 0;
          if (bad_left > 0) begin
            bad_left--; r_cnt = cfg_r_lat;
          end else begin
            busy = 0;
          end
        end
        if (busy && !mem_rvalid) begin
          if (r_cnt == 0) begin
            mem_rvalid = 1; mem_rlast = 1;
            mem_rid   = (bad_left > 0) ? rid_cur + 8'd1 : rid_cur;
            mem_rdata = cfg_fixed ? cfg_data : {$urandom, $urandom, $urandom, $urandom};
            mem_rresp = cfg_rand ? (($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00) : cfg_resp;
          end else begin
            r_cnt--;
          end
        end else if (!busy && cfg_noise && $urandom_range(0, 3) == 0) begin
          mem_rvalid = 1;
          mem_rid    = IW'($urandom);
          mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [2:0] p);
    int n;
    bit ok;
    n = 0; ok = 0;
    memctrl_arvalid = 1; memctrl_araddr = a; memctrl_arid = id; memctrl_arprot = p;
    while (!ok && n < 300) begin
      @(negedge aclk);
      ok = memctrl_arready;
      @(posedge aclk);
      n++;
    end
    #1;
    memctrl_arvalid = 0;
    memctrl_araddr  = $urandom;
    if (!ok) check("request_accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!e_arready && n < 300);
    if (!e_arready) check("fill_complete_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [DW-1:0] pat_a5;
    pat_a5 = {16{8'hA5}};

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_arready_low", memctrl_arready, 0);
    @(posedge aclk);
    #3 aresetn = 1;
    step(1);
    @(negedge aclk);
    check("first_cycle_after_release_arready", memctrl_arready, 1);
    step(1);

    // Basic fill with immediate AR ready and data two cycles later.
    cfg_ar_lat = 0; cfg_r_lat = 2; cfg_fixed = 1; cfg_data = pat_a5;
    cfg_resp = 2'b00; cfg_rand = 0; cfg_noise = 0; cfg_bad = 0;
    do_req(32'h0000_1234, 8'h05, 3'b010);
    wait_done();
    check("tp1_model_addr", m_addr, 32'h0000_1230);
    check("tp1_req_to_r", last_r - last_req, 4);
    check("tp1_cache_waddr", cache_waddr, 32'h0000_1230);
    check("tp1_cache_wdata", cache_wdata, pat_a5);
    check("tp1_mem_arid", mem_arid, 8'h05);
    step(1);

    // AR ready withheld for four cycles.
    cfg_ar_lat = 4; cfg_r_lat = 0; cfg_fixed = 0;
    do_req(32'h8000_00FF, 8'h3C, 3'b101);
    wait_done();
    check("tp2_ar_wait", t_ar - t_req, 5);
    check("tp2_model_addr", m_addr, 32'h8000_00F0);
    step(1);

    // Error response still writes the line.
    cfg_ar_lat = 1; cfg_r_lat = 1; cfg_resp = 2'b10;
    do_req(32'h0000_4008, 8'h11, 3'b000);
    wait_done();
    check("tp3_err_with_write", last_err - last_r, 0);
    cfg_resp = 2'b00;
    step(1);

    // Back-to-back requests with zero-wait memory.
    cfg_ar_lat = 0; cfg_r_lat = 0;
    do_req(32'h0000_0100, 8'h01, 3'b001);
    do_req(32'h0000_0200, 8'h02, 3'b001);
    check("tp4_accept_after_r", gap_from_r, 3);
    check("tp4_accept_to_accept", req_gap, 5);
    wait_done();
    step(1);

    // Asynchronous reset while the AR is pending.
    cfg_ar_lat = 20;
    do_req(32'h0000_9990, 8'h22, 3'b011);
    step(1);
    #2 aresetn = 0;
    @(negedge aclk);
    check("tp5_arvalid_in_reset", mem_arvalid, 0);
    check("tp5_arready_in_reset", memctrl_arready, 0);
    @(posedge aclk);
    @(posedge aclk);
    #3 aresetn = 1;
    cfg_ar_lat = 0;
    step(1);
    @(negedge aclk);
    check("tp5_arready_after_release", memctrl_arready, 1);
    step(1);
    do_req(32'h0000_ABCD, 8'h33, 3'b100);
    wait_done();
    check("tp5_fresh_waddr", cache_waddr, 32'h0000_ABC0);
    step(1);

    // Synchronous reset while waiting for R.
    cfg_r_lat = 8;
    do_req(32'h0000_7770, 8'h44, 3'b010);
    step(3);
    srst = 1;
    step(1);
    srst = 0;
    cfg_r_lat = 0;
    step(1);
    do_req(32'h0000_5550, 8'h45, 3'b010);
    wait_done();
    step(1);

`ifdef CACHE_RID_CHECK_EN
    // Foreign-ID beat is dropped, matching beat completes the fill.
    cfg_bad = 1; cfg_r_lat = 1;
    do_req(32'h0000_2220, 8'h05, 3'b000);
    wait_done();
    check("tp6_bad_beat_before_good", (last_err < last_r) ? 1 : 0, 1);
    cfg_bad = 0;
    step(1);
`endif

    // Randomized traffic with spurious R beats between fills.
    cfg_rand = 1; cfg_noise = 1; cfg_fixed = 0;
    for (int i = 0; i < 40; i++) begin
      cfg_ar_lat = $urandom_range(0, 3);
      cfg_r_lat  = $urandom_range(0, 3);
`ifdef CACHE_RID_CHECK_EN
      cfg_bad = $urandom_range(0, 1);
`endif
      do_req($urandom, IW'($urandom), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) != 0) begin
        wait_done();
        step($urandom_range(0, 2));
      end
    end
    wait_done();
    cfg_noise = 0;
    step(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
